// File: rtl/b20_enum.sv
// rtl/b20_enum.sv - Crypto1 filter-input candidate enumerator over one IDX partition
// Optional B20ENUM_MATCH_CNT_EN adds MATCH_CNT[16:0], counting VALID rising edges.
module b20_enum #(
  parameter logic [3:0] IDX = 4'd0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BIT_IN,
  input  logic        STB,
  output logic [19:0] KEY20,
  output logic        VALID,
  output logic        BUSY,
  output logic        DONE
`ifdef B20ENUM_MATCH_CNT_EN
  ,
  output logic [16:0] MATCH_CNT
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_EXHAUSTED
  } state_t;

  function automatic logic fn_a(input logic [3:0] v);
    return (v[2] & ~v[1] & ~v[0]) | (v[3] & ~v[2] & v[1]) |
           (v[3] & ~v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  function automatic logic fn_b(input logic [3:0] v);
    return (v[2] & v[1] & v[0]) | (~v[2] & v[1] & ~v[0]) |
           (~v[3] & v[2] & ~v[0]) | (~v[3] & ~v[2] & v[0]);
  endfunction

  function automatic logic fn_c(input logic [4:0] v);
    return (~v[3] & ~v[2] & ~v[1] & v[0]) | (v[4] & v[3] & v[1]) |
           (~v[4] & ~v[2] & v[1] & v[0]) | (v[4] & ~v[3] & ~v[0]) |
           (v[3] & v[2] & v[0]) | (v[3] & v[2] & v[1]);
  endfunction

  function automatic logic filt(input logic [19:0] x);
    return fn_c({fn_a(x[19:16]), fn_b(x[15:12]), fn_a(x[11:8]), fn_a(x[7:4]), fn_b(x[3:0])});
  endfunction

  state_t      state_q, state_d;
  logic [16:0] cand_q, cand_d;
  logic        bit_q, bit_d;
  logic        first_q, first_d;
  logic [15:0] key_q, key_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        hit;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    bit_d   = bit_q;
    first_d = first_q;
    key_d   = key_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = done_q;
    hit     = (filt({IDX, cand_q[15:0]}) == bit_q);
    case (state_q)
      ST_IDLE: begin
        if (STB) begin
          bit_d   = BIT_IN;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          first_d = 1'b0;
          // cand still holds the last match, so +1 resumes just past it
          cand_d  = first_q ? 17'd0 : cand_q + 17'd1;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (cand_q[16] || (!hit && cand_q[15:0] == 16'hFFFF)) begin
          done_d  = 1'b1;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_EXHAUSTED;
        end else if (hit) begin
          key_d   = cand_q[15:0];
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cand_d = cand_q + 17'd1;
        end
      end
      ST_EXHAUSTED: begin
        state_d = ST_EXHAUSTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      bit_q   <= 1'b0;
      first_q <= 1'b1;
      key_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      bit_q   <= bit_d;
      first_q <= first_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign KEY20 = {IDX, key_q};
  assign VALID = valid_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

`ifdef B20ENUM_MATCH_CNT_EN
  logic [16:0] mcnt_q, mcnt_d;

  always_comb begin
    mcnt_d = mcnt_q + {16'd0, valid_d & ~valid_q};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mcnt_q <= '0;
    end else begin
      mcnt_q <= mcnt_d;
    end
  end

  assign MATCH_CNT = mcnt_q;
`endif

endmodule

// File: tb/tb_b20_enum.sv
// tb/tb_b20_enum.sv - randomized model-checked bench for b20_enum (IDX=0 and IDX=A)
module tb_b20_enum;

  localparam logic [3:0] IDX_A = 4'hA;

  logic        clk = 1'b0;
  logic        rst    [2];
  logic        stb    [2];
  logic        bit_in [2];
  logic [19:0] key    [2];
  logic        valid  [2];
  logic        busy   [2];
  logic        done   [2];
`ifdef B20ENUM_MATCH_CNT_EN
  logic [16:0] mcnt   [2];
`endif

  always #5 clk = ~clk;

  b20_enum #(.IDX(4'h0)) u_dut0 (
    .CLK(clk), .RESET(rst[0]), .BIT_IN(bit_in[0]), .STB(stb[0]),
    .KEY20(key[0]), .VALID(valid[0]), .BUSY(busy[0]), .DONE(done[0])
`ifdef B20ENUM_MATCH_CNT_EN
    , .MATCH_CNT(mcnt[0])
`endif
  );

  b20_enum #(.IDX(IDX_A)) u_dut1 (
    .CLK(clk), .RESET(rst[1]), .BIT_IN(bit_in[1]), .STB(stb[1]),
    .KEY20(key[1]), .VALID(valid[1]), .BUSY(busy[1]), .DONE(done[1])
`ifdef B20ENUM_MATCH_CNT_EN
    , .MATCH_CNT(mcnt[1])
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: full match table per partition, plus enumeration state.
  bit   fv [2][65536];
  int   last_m  [2];
  bit   first_m [2];
  int   mcount  [2];
  int   idx_of  [2];

  function automatic bit ra(input int v);
    bit a = v[3], b = v[2], c = v[1], d = v[0];
    return (b && !c && !d) || (a && !b && c) || (a && !b && d) || (c && d);
  endfunction

  function automatic bit rb(input int v);
    bit a = v[3], b = v[2], c = v[1], d = v[0];
    return (b && c && d) || (!b && c && !d) || (!a && b && !d) || (!a && !b && d);
  endfunction

  function automatic bit rc(input bit a, input bit b, input bit c, input bit d, input bit e);
    return (!b && !c && !d && e) || (a && b && d) || (!a && !c && d && e) ||
           (a && !b && !e) || (b && c && e) || (b && c && d);
  endfunction

  function automatic bit ref_f(input int x);
    return rc(ra(x >> 16), rb(x >> 12), ra(x >> 8), ra(x >> 4), rb(x));
  endfunction

  function automatic int next_match(input int i, input int s, input bit b);
    for (int x = s; x < 65536; x++) if (fv[i][x] == b) return x;
    return -1;
  endfunction

  function automatic logic [19:0] exp_key(input int i);
    return {idx_of[i][3:0], 16'(last_m[i])};
  endfunction

  task automatic do_reset(input int i);
    rst[i] = 1'b1;
    @(posedge clk); #1;
    rst[i] = 1'b0;
    first_m[i] = 1'b1;
    last_m[i]  = 0;
    mcount[i]  = 0;
    chk("reset_key", key[i], exp_key(i));
    chk("reset_valid", valid[i], 0);
    chk("reset_busy", busy[i], 0);
    chk("reset_done", done[i], 0);
`ifdef B20ENUM_MATCH_CNT_EN
    chk("reset_mcnt", mcnt[i], 0);
`endif
  endtask

  // One STB request; noise drives STB/BIT_IN randomly while the search runs.
  task automatic search(input int i, input bit b, input bit noise);
    int s, m, lat;
    s = first_m[i] ? 0 : last_m[i] + 1;
    first_m[i] = 1'b0;
    m = next_match(i, s, b);
    stb[i] = 1'b1;
    bit_in[i] = b;
    @(posedge clk); #1;
    stb[i] = 1'b0;
    chk("busy_after_stb", busy[i], 1);
    lat = 0;
    while (!valid[i] && !done[i] && lat < 70000) begin
      if (noise) begin
        stb[i]    = 1'($urandom_range(0, 1));
        bit_in[i] = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
    end
    stb[i] = 1'b0;
    if (m >= 0) begin
      last_m[i] = m;
      mcount[i]++;
      chk("match_valid", valid[i], 1);
      chk("match_key", key[i], exp_key(i));
      chk("match_latency", lat, m - s + 1);
      chk("match_busy", busy[i], 0);
      chk("match_done", done[i], 0);
    end else begin
      chk("exh_done", done[i], 1);
      chk("exh_valid", valid[i], 0);
      chk("exh_busy", busy[i], 0);
      chk("exh_key", key[i], exp_key(i));
    end
`ifdef B20ENUM_MATCH_CNT_EN
    chk("match_cnt", mcnt[i], mcount[i]);
`endif
  endtask

  initial begin
    int s;
    bit b;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; stb[i] = 1'b0; bit_in[i] = 1'b0;
    end
    idx_of[0] = 0;
    idx_of[1] = int'(IDX_A);
    for (int i = 0; i < 2; i++)
      for (int x = 0; x < 65536; x++) fv[i][x] = ref_f((idx_of[i] << 16) | x);

    do_reset(0);
    do_reset(1);

    search(0, 1'b0, 1'b0);
    chk("first_key_bit0", key[0], 20'h00000);
    do_reset(0);
    search(0, 1'b1, 1'b0);
    chk("first_key_bit1", key[0], 20'h00001);

    for (int k = 0; k < 300; k++) search(1, 1'($urandom_range(0, 1)), 1'b1);

    // Abort a search in flight, then confirm the sweep restarts from zero.
    stb[1] = 1'b1;
    bit_in[1] = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    stb[1] = 1'b0;
    chk("mid_busy", busy[1], 1);
    do_reset(1);
    for (int k = 0; k < 20; k++) search(1, 1'($urandom_range(0, 1)), 1'b0);

    // Sweep IDX=0 to the end, picking the bit that skips the longest run.
    for (int k = 0; k < 70000 && !done[0]; k++) begin
      s = last_m[0] + 1;
      b = (s < 65536) ? !fv[0][s] : 1'b0;
      search(0, b, 1'b0);
    end
    chk("sweep_done", done[0], 1);

    stb[0] = 1'b1;
    bit_in[0] = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    stb[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_exh_done", done[0], 1);
    chk("post_exh_valid", valid[0], 0);
    chk("post_exh_busy", busy[0], 0);
    chk("post_exh_key", key[0], exp_key(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
